// File: rtl/id_ex_decode.sv
// rtl/id_ex_decode.sv - ID/EX pipeline register with MIPS subset decode
module id_ex_decode (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [5:0]  ex_aluc,
    output logic [4:0]  ex_shamt,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [4:0]  ex_wreg,
    output logic        ex_rf_w,
    output logic        ex_branch,
    output logic        ex_illegal
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [15:0] imm;

    assign opcode = id_instr[31:26];
    assign funct  = id_instr[5:0];
    assign imm    = id_instr[15:0];

    // decoded fields of the instruction currently in ID
    logic        dec_legal;
    logic        dec_branch;
    logic [5:0]  dec_aluc;
    logic [31:0] dec_b;
    logic [4:0]  dec_wreg;

    // register next-state
    logic        valid_d, illegal_d, branch_d, rf_w_d;
    logic [5:0]  aluc_d;
    logic [4:0]  shamt_d, wreg_d;
    logic [31:0] a_d, b_d;

    // registered state
    logic        valid_q, illegal_q, branch_q, rf_w_q;
    logic [5:0]  aluc_q;
    logic [4:0]  shamt_q, wreg_q;
    logic [31:0] a_q, b_q;

    // opcode/funct decode; control never depends on operand values
    always_comb begin
        dec_legal  = 1'b1;
        dec_branch = 1'b0;
        dec_aluc   = 6'b000000;
        dec_b      = id_rt_data;
        dec_wreg   = id_instr[20:16];
        unique case (opcode)
            6'b000000: begin
                dec_wreg = id_instr[15:11];
                unique case (funct)
                    6'b100001: dec_aluc = 6'b000000;
                    6'b100000: dec_aluc = 6'b000010;
                    6'b100011: dec_aluc = 6'b000001;
                    6'b100010: dec_aluc = 6'b000111;
                    6'b100100: dec_aluc = 6'b000011;
                    6'b100101: dec_aluc = 6'b000100;
                    6'b100110: dec_aluc = 6'b000110;
                    6'b100111: dec_aluc = 6'b000101;
                    6'b000000: dec_aluc = 6'b001000;
                    6'b000010: dec_aluc = 6'b001001;
                    6'b000011: dec_aluc = 6'b001010;
                    6'b000100: dec_aluc = 6'b001011;
                    6'b000110: dec_aluc = 6'b001101;
                    6'b000111: dec_aluc = 6'b001111;
                    6'b001010: dec_aluc = 6'b001110;
                    6'b001011: dec_aluc = 6'b001100;
                    default:   dec_legal = 1'b0;
                endcase
            end
            6'b001001: begin dec_aluc = 6'b000000; dec_b = {{16{imm[15]}}, imm}; end
            6'b001000: begin dec_aluc = 6'b000010; dec_b = {{16{imm[15]}}, imm}; end
            6'b001100: begin dec_aluc = 6'b000011; dec_b = {16'h0000, imm}; end
            6'b001101: begin dec_aluc = 6'b000100; dec_b = {16'h0000, imm}; end
            6'b001110: begin dec_aluc = 6'b000110; dec_b = {16'h0000, imm}; end
            6'b000100: begin
                dec_aluc   = 6'b000001;
                dec_branch = 1'b1;
                dec_wreg   = 5'd0;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // next-state selection: flush beats stall beats load
    always_comb begin
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        branch_d  = 1'b0;
        rf_w_d    = 1'b0;
        aluc_d    = 6'b000000;
        shamt_d   = 5'd0;
        wreg_d    = 5'd0;
        a_d       = 32'd0;
        b_d       = 32'd0;
        if (flush) begin
            // bubble: all defaults
        end else if (stall) begin
            valid_d   = valid_q;
            illegal_d = illegal_q;
            branch_d  = branch_q;
            rf_w_d    = rf_w_q;
            aluc_d    = aluc_q;
            shamt_d   = shamt_q;
            wreg_d    = wreg_q;
            a_d       = a_q;
            b_d       = b_q;
        end else if (id_valid) begin
            valid_d = 1'b1;
            if (dec_legal) begin
                branch_d = dec_branch;
                rf_w_d   = !dec_branch && (dec_wreg != 5'd0);
                aluc_d   = dec_aluc;
                shamt_d  = id_instr[10:6];
                wreg_d   = dec_wreg;
                a_d      = id_rs_data;
                b_d      = dec_b;
            end else begin
                illegal_d = 1'b1;
            end
        end
    end

    // EX register with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            branch_q  <= 1'b0;
            rf_w_q    <= 1'b0;
            aluc_q    <= 6'b000000;
            shamt_q   <= 5'd0;
            wreg_q    <= 5'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
        end else begin
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            branch_q  <= branch_d;
            rf_w_q    <= rf_w_d;
            aluc_q    <= aluc_d;
            shamt_q   <= shamt_d;
            wreg_q    <= wreg_d;
            a_q       <= a_d;
            b_q       <= b_d;
        end
    end

    assign ex_valid   = valid_q;
    assign ex_illegal = illegal_q;
    assign ex_branch  = branch_q;
    assign ex_rf_w    = rf_w_q;
    assign ex_aluc    = aluc_q;
    assign ex_shamt   = shamt_q;
    assign ex_wreg    = wreg_q;
    assign ex_a       = a_q;
    assign ex_b       = b_q;

endmodule

// File: tb/tb_id_ex_decode.sv
// tb/tb_id_ex_decode.sv - directed self-checking bench for id_ex_decode
module tb_id_ex_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [5:0]  ex_aluc;
    logic [4:0]  ex_shamt;
    logic [31:0] ex_a;
    logic [31:0] ex_b;
    logic [4:0]  ex_wreg;
    logic        ex_rf_w;
    logic        ex_branch;
    logic        ex_illegal;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    id_ex_decode dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_instr   (id_instr),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .stall      (stall),
        .flush      (flush),
        .ex_valid   (ex_valid),
        .ex_aluc    (ex_aluc),
        .ex_shamt   (ex_shamt),
        .ex_a       (ex_a),
        .ex_b       (ex_b),
        .ex_wreg    (ex_wreg),
        .ex_rf_w    (ex_rf_w),
        .ex_branch  (ex_branch),
        .ex_illegal (ex_illegal)
    );

    // observed outputs packed as {valid, illegal, branch, rf_w, aluc, shamt, wreg, a, b}
    logic [83:0] obs;
    assign obs = {ex_valid, ex_illegal, ex_branch, ex_rf_w, ex_aluc, ex_shamt,
                  ex_wreg, ex_a, ex_b};

    function automatic logic [83:0] pk(input logic v, input logic il, input logic br,
                                       input logic w, input logic [5:0] al,
                                       input logic [4:0] sh, input logic [4:0] wr,
                                       input logic [31:0] a, input logic [31:0] b);
        return {v, il, br, w, al, sh, wr, a, b};
    endfunction

    // drive on falling edge, then let one rising edge capture
    task automatic cyc(input logic v, input logic [31:0] ins, input logic [31:0] rs,
                       input logic [31:0] rt, input logic st, input logic fl);
        @(negedge clk);
        id_valid   = v;
        id_instr   = ins;
        id_rs_data = rs;
        id_rt_data = rt;
        stall      = st;
        flush      = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [83:0] exp;
        rst = 1'b1; id_valid = 1'b1; id_instr = 32'h2128FFFF;
        id_rs_data = 32'd5; id_rt_data = 32'd7; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp = '0;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs, exp);
        end
        @(negedge clk);
        id_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release got=%h want=%h", obs, exp);
        end
    endtask

    task automatic test_itype;
        logic [83:0] exp;
        cyc(1'b1, 32'h2128FFFF, 32'd5, 32'h1234, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b000010, 5'd31, 5'd8, 32'd5, 32'hFFFFFFFF);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL addi got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h35288000, 32'h11, 32'h22, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b000100, 5'd0, 5'd8, 32'h11, 32'h00008000);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL ori got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h30A4F0F0, 32'hAAAA5555, 32'h0, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b000011, 5'd3, 5'd4, 32'hAAAA5555, 32'h0000F0F0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL andi got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h24A48000, 32'h1, 32'h2, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b000000, 5'd0, 5'd4, 32'h1, 32'hFFFF8000);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL addiu got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h20200001, 32'h9, 32'h2, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 0, 6'b000010, 5'd0, 5'd0, 32'h9, 32'h00000001);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL addi_r0 got=%h want=%h", obs, exp); end
    endtask

    task automatic test_rtype;
        logic [83:0] exp;
        cyc(1'b1, 32'h00094100, 32'h77, 32'h3, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b001000, 5'd4, 5'd8, 32'h77, 32'h3);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sll got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h00221821, 32'h10, 32'h20, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b000000, 5'd0, 5'd3, 32'h10, 32'h20);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL addu got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h00221822, 32'h10, 32'h20, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b000111, 5'd0, 5'd3, 32'h10, 32'h20);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL sub got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h00221807, 32'hF, 32'hE, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b001111, 5'd0, 5'd3, 32'hF, 32'hE);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL srav got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h0022180B, 32'h0, 32'h0, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b001100, 5'd0, 5'd3, 32'h0, 32'h0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL movn got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h00000000, 32'h5, 32'h6, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 0, 6'b001000, 5'd0, 5'd0, 32'h5, 32'h6);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL nop got=%h want=%h", obs, exp); end
    endtask

    task automatic test_beq;
        logic [83:0] exp;
        cyc(1'b1, 32'h10220005, 32'hCAFE, 32'hBEEF, 1'b0, 1'b0);
        exp = pk(1, 0, 1, 0, 6'b000001, 5'd0, 5'd0, 32'hCAFE, 32'hBEEF);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL beq got=%h want=%h", obs, exp); end
    endtask

    task automatic test_illegal;
        logic [83:0] exp;
        exp = pk(1, 1, 0, 0, 6'b000000, 5'd0, 5'd0, 32'h0, 32'h0);
        cyc(1'b1, 32'hFC000000, 32'h123, 32'h456, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bad_opcode got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h00221801, 32'h123, 32'h456, 1'b0, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bad_funct got=%h want=%h", obs, exp); end
    endtask

    task automatic test_bubble;
        logic [83:0] exp;
        cyc(1'b0, 32'h2128FFFF, 32'd5, 32'd5, 1'b0, 1'b0);
        exp = '0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL invalid_load got=%h want=%h", obs, exp); end
    endtask

    task automatic test_stall_flush;
        logic [83:0] exp;
        cyc(1'b1, 32'h2128FFFF, 32'd5, 32'h9, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b000010, 5'd31, 5'd8, 32'd5, 32'hFFFFFFFF);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_load got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h35288000, 32'h99, 32'h88, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_1 got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'hFC000000, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_2 got=%h want=%h", obs, exp); end
        cyc(1'b0, 32'h00221822, 32'h1, 32'h1, 1'b1, 1'b0);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_3 got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h00221822, 32'h1, 32'h1, 1'b1, 1'b1);
        exp = '0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stall_flush got=%h want=%h", obs, exp); end
        cyc(1'b1, 32'h10220005, 32'h1, 32'h2, 1'b0, 1'b0);
        cyc(1'b1, 32'h00221821, 32'h1, 32'h2, 1'b0, 1'b1);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL flush got=%h want=%h", obs, exp); end
    endtask

    task automatic test_async_reset;
        logic [83:0] exp;
        cyc(1'b1, 32'h35288000, 32'h3, 32'h4, 1'b0, 1'b0);
        exp = pk(1, 0, 0, 1, 6'b000100, 5'd0, 5'd8, 32'h3, 32'h00008000);
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL pre_async got=%h want=%h", obs, exp); end
        #2 rst = 1'b1;
        #1;
        exp = '0;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL async_reset got=%h want=%h", obs, exp); end
        @(negedge clk);
        id_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL post_async got=%h want=%h", obs, exp); end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_rtype();
        test_beq();
        test_illegal();
        test_bubble();
        test_stall_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_decode.md
ID_EX_DECODE -- requirements
Module: id_ex_decode

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 id_valid  input  1  ID stage holds a valid instruction.
REQ-004 id_instr  input  32  MIPS instruction word from ID.
REQ-005 id_rs_data  input  32  register-file value of rs.
REQ-006 id_rt_data  input  32  register-file value of rt.
REQ-007 stall  input  1  hold EX register contents.
REQ-008 flush  input  1  replace EX register contents with a bubble.
REQ-009 ex_valid  output  1  EX register holds a valid instruction.
REQ-010 ex_aluc  output  6  ALU operation code for EX stage.
REQ-011 ex_shamt  output  5  shift amount (instr[10:6]).
REQ-012 ex_a  output  32  ALU operand a (always rs data).
REQ-013 ex_b  output  32  ALU operand b (rt data or extended immediate).
REQ-014 ex_wreg  output  5  destination register number.
REQ-015 ex_rf_w  output  1  register-file write enable.
REQ-016 ex_branch  output  1  instruction is beq.
REQ-017 ex_illegal  output  1  instruction not supported.

Function
REQ-018 All outputs SHALL be registered; decode result appears exactly one clk after capture.
REQ-019 Update priority per edge SHALL be: flush > stall > load.
REQ-020 Flush SHALL load a bubble: every output 0; flush with stall SHALL still bubble.
REQ-021 Stall without flush SHALL hold every output unchanged, any number of cycles.
REQ-022 Load with id_valid=0 SHALL produce a bubble; with id_valid=1 SHALL produce ex_valid=1 and decoded fields.
REQ-023 R-type (opcode 000000) funct->aluc SHALL be: 100001 addu->000000, 100000 add->000010, 100011 subu->000001, 100010 sub->000111, 100100 and->000011, 100101 or->000100, 100110 xor->000110, 100111 nor->000101, 000000 sll->001000, 000010 srl->001001, 000011 sra->001010, 000100 sllv->001011, 000110 srlv->001101, 000111 srav->001111, 001010 movz->001110, 001011 movn->001100.
REQ-024 R-type SHALL set ex_b=id_rt_data, ex_wreg=instr[15:11].
REQ-025 I-type opcode->aluc SHALL be: 001001 addiu->000000, 001000 addi->000010, 001100 andi->000011, 001101 ori->000100, 001110 xori->000110, 000100 beq->000001.
REQ-026 addi/addiu SHALL sign-extend instr[15:0] into ex_b; andi/ori/xori SHALL zero-extend.
REQ-027 I-type ALU ops SHALL set ex_wreg=instr[20:16].
REQ-028 beq SHALL set ex_b=id_rt_data, ex_branch=1, ex_rf_w=0, ex_wreg=0.
REQ-029 ex_rf_w SHALL be 1 for every legal non-beq instruction whose destination is nonzero; destination 0 SHALL give ex_rf_w=0 (all-zero word is a no-write sll).
REQ-030 Unsupported opcode or funct SHALL give ex_valid=1, ex_illegal=1, ex_aluc=000000, ex_rf_w=0, ex_branch=0, other fields 0.
REQ-031 ex_shamt SHALL carry instr[10:6] for every legal instruction, 0 for bubbles/illegal.
REQ-032 Decode SHALL be independent of id_rs_data/id_rt_data values (no data-dependent control).

Reset
REQ-033 rst=1 SHALL force every output to 0 immediately, without a clock edge, and hold while asserted.
REQ-034 Release of rst SHALL leave outputs 0 until the first qualifying load edge.

Verification
REQ-035 id_instr=0x2128FFFF (addi $8,$9,-1), rs=5 -> next cycle ex_aluc=000010, ex_a=5, ex_b=0xFFFFFFFF, ex_wreg=8, ex_rf_w=1.
REQ-036 id_instr=0x35288000 (ori $8,$9,0x8000) -> ex_aluc=000100, ex_b=0x00008000, ex_wreg=8, ex_rf_w=1.
REQ-037 id_instr=0x00094100 (sll $8,$9,4), rt=0x3 -> ex_aluc=001000, ex_shamt=4, ex_b=0x3, ex_wreg=8.
REQ-038 load addi, then stall 3 cycles with id_instr changing -> outputs unchanged; then stall+flush -> all outputs 0.
REQ-039 id_instr=0xFC000000 -> ex_valid=1, ex_illegal=1, ex_rf_w=0, ex_aluc=000000.
REQ-040 rst pulsed between clk edges while ex_valid=1 -> all outputs 0 before next edge.
